// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion, controller state encoding
// and the default pointer width. Used by both the read- and write-side controllers.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 11;
    // Conversion functions work on a fixed maximum width; callers zero-extend
    // their pointer in and size-cast the result back down.
    localparam int PTR_MAX = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fifo_state_e;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR-prefix from the MSB down; zero upper bits leave the low result intact.
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO controller signal bundle. The slave modport is the controller;
// the master modport is the consumer plus the write-pointer synchronizer.
interface fifo_rd_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ptr_width = PTR_WIDTH_DEF
);
    logic [ptr_width-1:0] rq2_wptr;
    logic                 rinc;
    logic                 rflush;
    logic [ptr_width-2:0] raddr;
    logic [ptr_width-1:0] rptr_g;
    logic                 rempty;
    logic                 ralmost_empty;
    logic [ptr_width-1:0] rlevel;
    logic                 rflush_done;
    logic                 rerr_underflow;

    modport master (
        output rq2_wptr, rinc, rflush,
        input  raddr, rptr_g, rempty, ralmost_empty, rlevel, rflush_done, rerr_underflow
    );

    modport slave (
        input  rq2_wptr, rinc, rflush,
        output raddr, rptr_g, rempty, ralmost_empty, rlevel, rflush_done, rerr_underflow
    );
endinterface

// File: rtl/fifo_gray_cnt.sv
// Binary/Gray pointer register with increment enable and synchronous load.
// The Gray copy is registered from the next binary value so it never glitches.
module fifo_gray_cnt
    import fifo_pkg::*;
#(
    parameter int width = PTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [width-1:0] load_bin,
    output logic [width-2:0] addr,
    output logic [width-1:0] gray,
    output logic [width-1:0] bin_next
);
    logic [width-1:0] bin_q;
    logic [width-1:0] gray_q;

    // Load wins over increment; increment wraps naturally modulo 2**width.
    assign bin_next = load ? load_bin : bin_q + width'(inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= width'(bin2gray(PTR_MAX'(bin_next)));
        end
    end

    assign addr = bin_q[width-2:0];
    assign gray = gray_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-domain controller: read pointer, empty/almost-empty/level flags
// and one-shot flush. Define FIFO_RD_UNDERFLOW_CHK_EN for the sticky underflow flag.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ptr_width = PTR_WIDTH_DEF,
    parameter int ae_thresh = 4
) (
    input  logic          rclk,
    input  logic          rrst,
    fifo_rd_ctrl_if.slave rif
);
    localparam logic [ptr_width-1:0] AE_LVL = ptr_width'(ae_thresh);

    fifo_state_e          state_q, state_d;
    logic                 pop;
    logic                 load;
    logic [ptr_width-1:0] wbin_s;
    logic [ptr_width-1:0] bin_next;
    logic [ptr_width-1:0] gray_next;
    logic [ptr_width-1:0] lvl_next;
    logic                 rempty_q;
    logic                 rae_q;
    logic [ptr_width-1:0] rlevel_q;
    logic                 rdone_q;

    assign wbin_s    = ptr_width'(gray2bin(PTR_MAX'(rif.rq2_wptr)));
    assign gray_next = ptr_width'(bin2gray(PTR_MAX'(bin_next)));
    assign lvl_next  = wbin_s - bin_next;

    fifo_gray_cnt #(.width(ptr_width)) u_rptr (
        .clk      (rclk),
        .rst      (rrst),
        .inc      (pop),
        .load     (load),
        .load_bin (wbin_s),
        .addr     (rif.raddr),
        .gray     (rif.rptr_g),
        .bin_next (bin_next)
    );

    always_ff @(posedge rclk) begin
        if (rrst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // A flush request swallows any pop in the same cycle; FLUSH always lasts one cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            RUN: begin
                if (rif.rflush) state_d = FLUSH;
                else            pop     = rif.rinc & ~rempty_q;
            end
            FLUSH: begin
                state_d = RUN;
                load    = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rempty_q <= 1'b1;
            rae_q    <= 1'b1;
            rlevel_q <= '0;
            rdone_q  <= 1'b0;
        end else begin
            rdone_q <= (state_q == FLUSH);
            if (state_q == FLUSH) begin
                rempty_q <= 1'b1;
                rae_q    <= 1'b1;
                rlevel_q <= '0;
            end else begin
                rempty_q <= (gray_next == rif.rq2_wptr);
                rae_q    <= (lvl_next <= AE_LVL);
                rlevel_q <= lvl_next;
            end
        end
    end

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    logic rerr_q;

    always_ff @(posedge rclk) begin
        if (rrst)                                                 rerr_q <= 1'b0;
        else if (state_q == FLUSH)                                rerr_q <= 1'b0;
        else if (!rif.rflush && rif.rinc && rempty_q)             rerr_q <= 1'b1;
    end

    assign rif.rerr_underflow = rerr_q;
`else
    assign rif.rerr_underflow = 1'b0;
`endif

    assign rif.rempty        = rempty_q;
    assign rif.ralmost_empty = rae_q;
    assign rif.rlevel        = rlevel_q;
    assign rif.rflush_done   = rdone_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl (ptr_width=4, ae_thresh=2): directed scenarios then random
// traffic, every cycle compared against an entry-counting reference model.
module tb_fifo_rd_ctrl;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic rclk;
    logic rrst;
    int   n_assert;
    int   n_fail;

    // Reference model: plain counts of entries written and consumed.
    int   wr_cnt;
    int   rd_cnt;
    int   m_lvl;
    bit   m_done;
    bit   m_err;
    bit   m_fl_pend;

    fifo_rd_ctrl_if #(.ptr_width(4)) rif ();

    fifo_rd_ctrl #(.ptr_width(4), .ae_thresh(2)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .rif  (rif)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b % 16);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (wr=%0d rd=%0d)", tag, obs, exp, wr_cnt, rd_cnt);
        end
    endtask

    task automatic check_all();
        chk("raddr",         32'(rif.raddr),          32'(rd_cnt % 8));
        chk("rptr_g",        32'(rif.rptr_g),         32'(gray4(rd_cnt)));
        chk("rempty",        32'(rif.rempty),         32'(m_lvl == 0));
        chk("ralmost_empty", 32'(rif.ralmost_empty),  32'(m_lvl <= 2));
        chk("rlevel",        32'(rif.rlevel),         32'(m_lvl));
        chk("rflush_done",   32'(rif.rflush_done),    32'(m_done));
        chk("rerr_underflow",32'(rif.rerr_underflow), 32'(m_err));
    endtask

    // One rclk cycle: optionally write one entry, present rinc/rflush, update model, check.
    task automatic step(input bit inc, input bit flush, input bit wstep);
        wr_cnt       = wr_cnt + int'(wstep);
        rif.rq2_wptr = gray4(wr_cnt);
        rif.rinc     = inc;
        rif.rflush   = flush;
        @(posedge rclk);
        if (m_fl_pend) begin
            rd_cnt    = wr_cnt;
            m_done    = 1'b1;
            m_err     = 1'b0;
            m_fl_pend = 1'b0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_fl_pend = 1'b1;
            end else if (inc) begin
                if (m_lvl > 0) rd_cnt++;
                else if (UF_EN) m_err = 1'b1;
            end
        end
        m_lvl = wr_cnt - rd_cnt;
        #1;
        check_all();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        rd_cnt    = 0;
        m_lvl     = 0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_fl_pend = 1'b0;

        // Reset wins over simultaneous pop and flush requests.
        rrst         = 1'b1;
        rif.rinc     = 1'b1;
        rif.rflush   = 1'b1;
        rif.rq2_wptr = '0;
        repeat (2) @(posedge rclk);
        #1;
        check_all();
        rrst = 1'b0;

        // Five entries appear at once, then three pops.
        wr_cnt = 4;
        step(1'b0, 1'b0, 1'b1);
        chk("lvl5", 32'(rif.rlevel), 32'd5);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk("raddr3", 32'(rif.raddr), 32'd3);

        // Wrap: trail reads up to 8, write to 16, then drain all eight entries.
        for (int i = 0; i < 20 && wr_cnt < 8; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20 && rd_cnt < 8; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
        chk("full_lvl", 32'(rif.rlevel), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);

        // Flush at level 6 with a coincident pop request.
        repeat (6) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("flush_ptr", 32'(rif.rptr_g), 32'(rif.rq2_wptr));
        step(1'b0, 1'b0, 1'b0);

        // Pops while empty, then a flush clears the error flag.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Flush held high while writes and pops keep arriving.
        repeat (6) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Pop the last entry in the same cycle as a new write arrives.
        for (int i = 0; i < 10 && m_lvl > 0; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("no_glitch", 32'(rif.rempty), 32'd0);
        step(1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flushes; writes never overfill the FIFO.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 (wr_cnt - rd_cnt < 8) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
